// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly: a +/- b*w (or b*conj(w)), three-stage valid/ready pipeline
// with round-half-up, saturation and a sticky saturation flag/counter.
module butterfly_pipe #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_re,
    input  logic [W-1:0]     a_im,
    input  logic [W-1:0]     b_re,
    input  logic [W-1:0]     b_im,
    input  logic [W-1:0]     w_re,
    input  logic [W-1:0]     w_im,
    input  logic             inverse,
    input  logic             scale,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_a_re,
    output logic [W-1:0]     out_a_im,
    output logic [W-1:0]     out_b_re,
    output logic [W-1:0]     out_b_im,
    output logic             sat_flag,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             clr_sat
);

    localparam int PW = 2*W + 1;
    localparam int SW = 2*W + 2;

    localparam logic signed [SW-1:0] RND_FULL = SW'(2**(W-2));
    localparam logic signed [SW-1:0] RND_HALF = SW'(2**(W-1));
    localparam logic signed [SW-1:0] SAT_MAX  = SW'(2**(W-1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN  = SW'(-(2**(W-1)));

    // Returns {saturated, value}.
    function automatic logic [W:0] round_sat(input logic signed [SW-1:0] s,
                                             input logic half);
        logic signed [SW-1:0] r;
        if (half)
            r = (s + RND_HALF) >>> W;
        else
            r = (s + RND_FULL) >>> (W-1);
        if (r > SAT_MAX)
            round_sat = {1'b1, SAT_MAX[W-1:0]};
        else if (r < SAT_MIN)
            round_sat = {1'b1, SAT_MIN[W-1:0]};
        else
            round_sat = {1'b0, r[W-1:0]};
    endfunction

    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    logic deliver;

    logic signed [W-1:0]  s1_a_re, s1_a_im;
    logic signed [PW-1:0] s1_p_re, s1_p_im;
    logic                 s1_scale;

    logic signed [SW-1:0] s2_sa_re, s2_sa_im, s2_sb_re, s2_sb_im;
    logic                 s2_scale;

    logic                 s3_sat;

    logic signed [PW-1:0] ebr, ebi, ewr, ewi, p_re, p_im;
    logic signed [SW-1:0] ext_a_re, ext_a_im, sa_re, sa_im, sb_re, sb_im;
    logic [W:0]           q_ar, q_ai, q_br, q_bi;

    // Ready propagates back through the chain so bubbles collapse.
    always_comb begin
        adv3      = !v3 || out_ready;
        adv2      = !v2 || adv3;
        adv1      = !v1 || adv2;
        in_ready  = adv1;
        out_valid = v3;
        deliver   = v3 && out_ready;
    end

    always_comb begin
        ebr = PW'($signed(b_re));
        ebi = PW'($signed(b_im));
        ewr = PW'($signed(w_re));
        ewi = PW'($signed(w_im));
        if (inverse) begin
            p_re = ebr * ewr + ebi * ewi;
            p_im = ebi * ewr - ebr * ewi;
        end else begin
            p_re = ebr * ewr - ebi * ewi;
            p_im = ebr * ewi + ebi * ewr;
        end
    end

    always_comb begin
        ext_a_re = SW'(s1_a_re) <<< (W-1);
        ext_a_im = SW'(s1_a_im) <<< (W-1);
        sa_re    = ext_a_re + SW'(s1_p_re);
        sa_im    = ext_a_im + SW'(s1_p_im);
        sb_re    = ext_a_re - SW'(s1_p_re);
        sb_im    = ext_a_im - SW'(s1_p_im);
    end

    always_comb begin
        q_ar = round_sat(s2_sa_re, s2_scale);
        q_ai = round_sat(s2_sa_im, s2_scale);
        q_br = round_sat(s2_sb_re, s2_scale);
        q_bi = round_sat(s2_sb_im, s2_scale);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_p_re  <= '0;
            s1_p_im  <= '0;
            s1_scale <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_a_re  <= $signed(a_re);
                s1_a_im  <= $signed(a_im);
                s1_p_re  <= p_re;
                s1_p_im  <= p_im;
                s1_scale <= scale;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            s2_sa_re <= '0;
            s2_sa_im <= '0;
            s2_sb_re <= '0;
            s2_sb_im <= '0;
            s2_scale <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2_sa_re <= sa_re;
                s2_sa_im <= sa_im;
                s2_sb_re <= sb_re;
                s2_sb_im <= sb_im;
                s2_scale <= s1_scale;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            out_a_re <= '0;
            out_a_im <= '0;
            out_b_re <= '0;
            out_b_im <= '0;
            s3_sat   <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                out_a_re <= q_ar[W-1:0];
                out_a_im <= q_ai[W-1:0];
                out_b_re <= q_br[W-1:0];
                out_b_im <= q_bi[W-1:0];
                s3_sat   <= q_ar[W] | q_ai[W] | q_br[W] | q_bi[W];
            end
        end
    end

    // A clear coinciding with a saturated delivery restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            sat_cnt  <= '0;
        end else if (deliver && s3_sat) begin
            sat_flag <= 1'b1;
            if (clr_sat)
                sat_cnt <= CNT_W'(1);
            else if (sat_cnt != '1)
                sat_cnt <= sat_cnt + 1'b1;
        end else if (clr_sat) begin
            sat_flag <= 1'b0;
            sat_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Randomized bench for butterfly_pipe: integer reference model with a result scoreboard,
// plus directed cases for rounding, saturation, back-pressure and mid-flight reset.
module tb_butterfly_pipe;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
    logic             inverse = 1'b0, scale = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_a_re, out_a_im, out_b_re, out_b_im;
    logic             sat_flag;
    logic [CNT_W-1:0] sat_cnt;
    logic             clr_sat = 1'b0;

    butterfly_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im), .inverse(inverse), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a_re(out_a_re), .out_a_im(out_a_im), .out_b_re(out_b_re), .out_b_im(out_b_im),
        .sat_flag(sat_flag), .sat_cnt(sat_cnt), .clr_sat(clr_sat)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int fdiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Exact value / 2^k rounded half-up, then clamped; returns {saturated, value}.
    function automatic logic [W:0] res(input int v, input bit scl);
        int d, r, lim;
        d   = scl ? (1 << W) : (1 << (W-1));
        lim = 1 << (W-1);
        r   = fdiv(v + d/2, d);
        if (r > lim - 1) return {1'b1, W'(lim - 1)};
        if (r < -lim)    return {1'b1, W'(-lim)};
        return {1'b0, W'(r)};
    endfunction

    function automatic logic [4*W:0] model(input logic [W-1:0] ar_, ai_, br_, bi_, wr_, wi_,
                                           input bit inv, input bit scl);
        int ar, ai, br, bi, wr, wi, pr, pi, base;
        logic [W:0] oar, oai, obr, obi;
        ar = $signed(ar_); ai = $signed(ai_);
        br = $signed(br_); bi = $signed(bi_);
        wr = $signed(wr_); wi = $signed(wi_);
        if (inv) begin
            pr = br*wr + bi*wi;
            pi = bi*wr - br*wi;
        end else begin
            pr = br*wr - bi*wi;
            pi = br*wi + bi*wr;
        end
        base = 1 << (W-1);
        oar = res(ar*base + pr, scl);
        oai = res(ai*base + pi, scl);
        obr = res(ar*base - pr, scl);
        obi = res(ai*base - pi, scl);
        return {oar[W] | oai[W] | obr[W] | obi[W],
                oar[W-1:0], oai[W-1:0], obr[W-1:0], obi[W-1:0]};
    endfunction

    logic [4*W:0] exp_q[$];
    int           m_cnt = 0;
    bit           m_flag = 1'b0;
    int           n_acc = 0;
    bit           dlv, dsat;
    bit           rand_ready = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_sat", {sat_flag, sat_cnt}, 0);
            check("rst_data", {out_a_re, out_a_im, out_b_re, out_b_im}, 0);
            exp_q.delete();
            m_flag = 1'b0;
            m_cnt  = 0;
        end else begin
            check("sat_flag", sat_flag, m_flag);
            check("sat_cnt", sat_cnt, m_cnt);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, inverse, scale));
                n_acc++;
            end
            dlv  = 1'b0;
            dsat = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", out_valid, 0);
                end else begin
                    check("result", {out_a_re, out_a_im, out_b_re, out_b_im}, exp_q[0][4*W-1:0]);
                    if (out_ready) begin
                        dsat = exp_q[0][4*W];
                        void'(exp_q.pop_front());
                        dlv = 1'b1;
                    end
                end
            end
            if (clr_sat) begin
                m_flag = 1'b0;
                m_cnt  = 0;
            end
            if (dlv && dsat) begin
                m_flag = 1'b1;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] ar, ai, br, bi, wr, wi, input bit inv, input bit scl);
        bit acc;
        int budget;
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        inverse = inv; scale = scl; in_valid = 1'b1;
        budget = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            budget++;
            if (budget > 300) begin
                check("send_timeout", in_ready, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Sends one set into an empty pipe; leaves the result visible at a negedge.
    task automatic one_shot(input logic [W-1:0] ar, ai, br, bi, wr, wi, input bit inv,
                            input bit scl, output int lat);
        send(ar, ai, br, bi, wr, wi, inv, scl);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 1000) begin
            tick();
            b++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'h00;
            default: return W'($urandom);
        endcase
    endfunction

    int lat;
    int acc0;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", in_ready, 1);

        out_ready = 1'b1;
        one_shot(8'h20, 8'hE0, 8'h00, 8'h00, W'($urandom), W'($urandom), 1'b0, 1'b0, lat);
        check("r31_latency", lat, 3);
        check("r31_out_a", {out_a_re, out_a_im}, 16'h20E0);
        check("r31_out_b", {out_b_re, out_b_im}, 16'h20E0);
        tick();
        check("r31_no_sat", sat_flag, 0);

        one_shot(8'h40, 8'h00, 8'h40, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0, lat);
        check("r32_out_a_re", out_a_re, 8'h7F);
        check("r32_out_b_re", out_b_re, 8'h01);
        tick();
        check("r32_sat", {sat_flag, sat_cnt}, {1'b1, 8'd1});
        one_shot(8'h40, 8'h00, 8'h40, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b1, lat);
        check("r32s_out_a_re", out_a_re, 8'h40);
        check("r32s_out_b_re", out_b_re, 8'h00);
        tick();
        check("r32s_sat_cnt", sat_cnt, 1);

        one_shot(8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h7F, 1'b0, 1'b0, lat);
        check("r33_fwd", {out_a_re, out_b_re}, 16'hC140);
        tick();
        one_shot(8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h7F, 1'b1, 1'b0, lat);
        check("r33_inv", {out_a_re, out_b_re}, 16'h40C1);
        tick();

        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("clr_sat", {sat_flag, sat_cnt}, 0);

        // Back-pressure: stream of 8 while the output is stalled.
        out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(pick(), pick(), pick(), pick(), pick(), pick(),
                         1'($urandom), 1'($urandom));
            end
            begin
                repeat (6) tick();
                check("r34_held", n_acc - acc0, 3);
                check("r34_in_ready_low", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        drain();
        check("r34_count", n_acc - acc0, 8);

        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(pick(), pick(), pick(), pick(), pick(), pick(), 1'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        drain();

        // Counter saturation, then clear coinciding with a saturated delivery.
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        for (int i = 0; i < 300; i++)
            send(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0);
        drain();
        tick();
        check("r35_cnt_held", {sat_flag, sat_cnt}, {1'b1, 8'hFF});
        out_ready = 1'b0;
        one_shot(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0, lat);
        tick();
        out_ready = 1'b1;
        clr_sat   = 1'b1;
        tick();
        clr_sat = 1'b0;
        check("r35_clr_coincide", {sat_flag, sat_cnt}, {1'b1, 8'd1});

        // Reset with a full pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(pick(), pick(), pick(), pick(), pick(), pick(), 1'b0, 1'b0);
        tick();
        check("r36_full", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("r36_async_clear", out_valid, 0);
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("r36_in_ready", in_ready, 1);
        repeat (10) tick();
        check("r36_no_stale", out_valid, 0);
        one_shot(8'h20, 8'hE0, 8'h00, 8'h00, 8'h11, 8'h22, 1'b0, 1'b0, lat);
        check("r36_new_latency", lat, 3);
        tick();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 SHALL have parameter W, default 8: data width of every real/imag component, signed Q1.(W-1).
REQ-002 SHALL have parameter CNT_W, default 8: width of the saturation event counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: input operand set is valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-007 SHALL have ports a_re, a_im, b_re, b_im, input, W each: even (a) and odd (b) complex operands.
REQ-008 SHALL have ports w_re, w_im, input, W each: twiddle factor.
REQ-009 SHALL have port inverse, input, 1: 1 = multiply b by conj(w); sampled with the operands.
REQ-010 SHALL have port scale, input, 1: 1 = halve both results; sampled with the operands.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-013 SHALL have ports out_a_re, out_a_im, out_b_re, out_b_im, output, W each: results.
REQ-014 SHALL have port sat_flag, output, 1: sticky flag, set when any component of a delivered result saturated.
REQ-015 SHALL have port sat_cnt, output, CNT_W: count of delivered results with at least one saturated component.
REQ-016 SHALL have port clr_sat, input, 1: synchronous clear of sat_flag and sat_cnt.

Function
REQ-017 SHALL accept an operand set when in_valid && in_ready, and deliver a result when out_valid && out_ready.
REQ-018 SHALL be a 3-stage pipeline: S1 registers operands and the complex product; S2 registers the extended sum and difference; S3 registers the rounded, saturated outputs. Minimum latency is 3 cycles, accept to out_valid.
REQ-019 Each stage k SHALL advance when !v_k || ready_(k+1); ready of S3 is out_ready; in_ready = !v_1 || ready_2 (bubbles collapse, no combinational path from in_valid to in_ready).
REQ-020 Results SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern; a full pipeline holds 3 results.
REQ-021 Product P = b*w (inverse=0) or b*conj(w) (inverse=1): P_re = b_re*w_re -/+ b_im*w_im, P_im = b_re*w_im... signs per conj, full precision 2W+1 bits, no intermediate truncation.
REQ-022 Extended sums SHALL be computed at 2W+2 bits: A = a <<< (W-1); SA = A + P; SB = A - P, per component.
REQ-023 Rounding SHALL be round-half-up: add 2^(W-2) then arithmetic shift right by W-1 when scale=0; add 2^(W-1) then shift right by W when scale=1.
REQ-024 The shifted value SHALL saturate to [-2^(W-1), 2^(W-1)-1]; wrap-around is forbidden.
REQ-025 The per-result saturation indication SHALL be the OR over the four components, travelling with the result.
REQ-026 On each delivered result with saturation, sat_flag SHALL become 1 and sat_cnt SHALL increment, holding at 2^CNT_W-1 (no wrap).
REQ-027 When clr_sat coincides with a delivered saturated result, the clear takes effect and then that event applies: sat_flag=1, sat_cnt=1.
REQ-028 Outputs SHALL hold stable while out_valid && !out_ready.

Reset
REQ-029 While rst_n=0: all stage valids, out_valid, sat_flag and sat_cnt SHALL be 0; all data outputs SHALL be 0; in_ready SHALL be 1 one cycle after release.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight results immediately; no stale result appears after release.

Verification (W=8)
REQ-031 a=(0x20,0xE0), b=0, any w, scale=0 -> after 3 cycles out_a=out_b=(0x20,0xE0), no saturation.
REQ-032 a=(0x40,0), b=(0x40,0), w=(0x7F,0), scale=0 -> out_a_re=0x7F (saturated), out_b_re=0x01, sat_flag=1, sat_cnt=1; with scale=1 -> out_a_re=0x40, out_b_re=0x00, no saturation.
REQ-033 a=0, b=(0,0x40), w=(0,0x7F): inverse=0 -> out_a_re=0xC1, out_b_re=0x40; inverse=1 -> out_a_re=0x40, out_b_re=0xC1.
REQ-034 Back-to-back stream of 8 sets with out_ready low cycles 4-8 -> in_ready drops after 3 held results, all 8 results appear in order, each exactly once.
REQ-035 300 saturating results, then clr_sat coinciding with a saturating delivery -> sat_cnt holds 0xFF before the clear, then reads sat_flag=1, sat_cnt=1.
REQ-036 rst_n pulsed low with 3 results in flight -> out_valid=0 during reset and no result emitted after release until new input is accepted.
